// File: rtl/uart_rx_fifo_pkg.sv
// Shared types and default sizing for the UART receive buffer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: rx_entry_t {perr, data} entry layout at the default width, and the
// default DATA_WIDTH / DEPTH / TIMEOUT_CYC / CW values used by uart_rx_fifo.
package uart_rx_fifo_pkg;

  localparam int RX_DATA_WIDTH  = 32;
  localparam int RX_FIFO_DEPTH  = 16;
  localparam int RX_TIMEOUT_CYC = 1024;
  localparam int RX_FIFO_CW     = $clog2(RX_FIFO_DEPTH) + 1;

  typedef struct packed {
    logic                     perr;
    logic [RX_DATA_WIDTH-1:0] data;
  } rx_entry_t;

endpackage

// File: rtl/uart_pulse_sync.sv
// Level synchroniser with rising-edge detect: turns a slow-domain level into a one-PCLK pulse.
// Latency: pulse is high in the 3rd PCLK cycle after the level rises (2 sync flops + registered detect).
// Backpressure: none; a level that stays high yields exactly one pulse.
//
// Ports:
//   PCLK    in  system clock
//   PRESET  in  synchronous active-high reset
//   level   in  asynchronous input level
//   pulse   out registered one-cycle pulse on a synchronised rising edge
module uart_pulse_sync (
  input  logic PCLK,
  input  logic PRESET,
  input  logic level,
  output logic pulse
);

  // [0],[1] are the metastability pair; [2] holds the previous synced value.
  logic [2:0] sync_q;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      sync_q <= '0;
      pulse  <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], level};
      pulse  <= sync_q[1] & ~sync_q[2];
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: brings rx_done/rx_error into PCLK and queues {perr, data} for APB pops.
// Latency: entry becomes visible at the head 1 PCLK after push_p (4 PCLK after rx_done rises).
// Backpressure: none toward the receiver; a word arriving while full is dropped and sets overrun.
//
// Ports:
//   PCLK, PRESET                 clock, synchronous active-high reset
//   rx_done, rx_error, rx_data_in receiver word-complete / parity-error levels and word
//   rd_en, flush, ovr_clr        pop request, discard all, clear sticky overrun
//   threshold                    level interrupt threshold (0 disables)
//   rd_data, rd_perr             show-ahead head entry, 0 when empty
//   empty, full, count           occupancy status
//   overrun, level_irq           sticky overrun, count >= threshold
//   rx_timeout                   idle-with-data timeout
// Config macro: UART_RX_TIMEOUT_EN enables the inactivity timeout; otherwise rx_timeout is 0.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter  int DATA_WIDTH  = RX_DATA_WIDTH,
  parameter  int DEPTH       = RX_FIFO_DEPTH,
  parameter  int TIMEOUT_CYC = RX_TIMEOUT_CYC,
  localparam int CW          = $clog2(DEPTH) + 1,
  localparam int AW          = $clog2(DEPTH)
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  rx_done,
  input  logic                  rx_error,
  input  logic [DATA_WIDTH-1:0] rx_data_in,
  input  logic                  rd_en,
  input  logic                  flush,
  input  logic                  ovr_clr,
  input  logic [CW-1:0]         threshold,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_perr,
  output logic                  empty,
  output logic                  full,
  output logic [CW-1:0]         count,
  output logic                  overrun,
  output logic                  level_irq,
  output logic                  rx_timeout
);

  typedef struct packed {
    logic                  perr;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   cnt;
  logic            err_pend;
  logic            push_p;
  logic            err_p;
  logic            do_push;
  logic            do_pop;

  uart_pulse_sync u_done_sync (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .level  (rx_done),
    .pulse  (push_p)
  );

  uart_pulse_sync u_err_sync (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .level  (rx_error),
    .pulse  (err_p)
  );

  assign empty  = (cnt == '0);
  assign full   = (cnt == CW'(DEPTH));
  assign count  = cnt;
  assign do_pop = rd_en & ~empty;
  // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
  assign do_push = push_p & (~full | do_pop);

  always_ff @(posedge PCLK) begin
    if (do_push && !flush) begin
      // An error pulse coincident with the push belongs to this entry.
      mem[wr_ptr] <= '{perr: err_pend | err_p, data: rx_data_in};
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      err_pend <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      err_pend <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
      // Any push consumes the pending error, including a dropped one.
      if (push_p)     err_pend <= 1'b0;
      else if (err_p) err_pend <= 1'b1;
    end
  end

  // Overrun set wins over a same-cycle clear; flush suppresses the set.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      overrun <= 1'b0;
    end else if (push_p && full && !do_pop && !flush) begin
      overrun <= 1'b1;
    end else if (ovr_clr) begin
      overrun <= 1'b0;
    end
  end

  assign rd_data   = empty ? '0 : mem[rd_ptr].data;
  assign rd_perr   = empty ? 1'b0 : mem[rd_ptr].perr;
  assign level_irq = (threshold != '0) && (cnt >= threshold);

`ifdef UART_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_cnt;

  // Counts idle cycles while data waits; saturates at the terminal value.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      tmo_cnt <= '0;
    end else if (empty || push_p || do_pop || flush) begin
      tmo_cnt <= '0;
    end else if (tmo_cnt != TW'(TIMEOUT_CYC - 1)) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign rx_timeout = (tmo_cnt == TW'(TIMEOUT_CYC - 1));
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = (TIMEOUT_CYC != 0);
  assign rx_timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo against a queue-based reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_rx_fifo;
  import uart_rx_fifo_pkg::*;

  localparam int DW    = RX_DATA_WIDTH;
  localparam int DEPTH = RX_FIFO_DEPTH;
  localparam int CW    = RX_FIFO_CW;
  localparam int TMO   = RX_TIMEOUT_CYC;

  logic          PCLK = 1'b0;
  logic          PRESET = 1'b1;
  logic          rx_done = 1'b0;
  logic          rx_error = 1'b0;
  logic [DW-1:0] rx_data_in = '0;
  logic          rd_en = 1'b0;
  logic          flush = 1'b0;
  logic          ovr_clr = 1'b0;
  logic [CW-1:0] threshold = '0;
  logic [DW-1:0] rd_data;
  logic          rd_perr;
  logic          empty;
  logic          full;
  logic [CW-1:0] count;
  logic          overrun;
  logic          level_irq;
  logic          rx_timeout;

  uart_rx_fifo dut (
    .PCLK       (PCLK),
    .PRESET     (PRESET),
    .rx_done    (rx_done),
    .rx_error   (rx_error),
    .rx_data_in (rx_data_in),
    .rd_en      (rd_en),
    .flush      (flush),
    .ovr_clr    (ovr_clr),
    .threshold  (threshold),
    .rd_data    (rd_data),
    .rd_perr    (rd_perr),
    .empty      (empty),
    .full       (full),
    .count      (count),
    .overrun    (overrun),
    .level_irq  (level_irq),
    .rx_timeout (rx_timeout)
  );

  always #5 PCLK = ~PCLK;

  // Reference model: queue of entries plus sticky overrun and pending-error flag.
  rx_entry_t q[$];
  bit        m_ovr  = 1'b0;
  bit        m_pend = 1'b0;
  bit        m_tmo  = 1'b0;
  int        total  = 0;
  int        bad    = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    int n;
    n = q.size();
    chk({tag, ".count"},     64'(count),     64'(n));
    chk({tag, ".empty"},     64'(empty),     64'(n == 0));
    chk({tag, ".full"},      64'(full),      64'(n == DEPTH));
    chk({tag, ".overrun"},   64'(overrun),   64'(m_ovr));
    chk({tag, ".level_irq"}, 64'(level_irq), 64'((threshold != 0) && (n >= int'(threshold))));
    chk({tag, ".timeout"},   64'(rx_timeout), 64'(m_tmo));
    chk({tag, ".rd_data"},   64'(rd_data),   (n == 0) ? 64'd0 : 64'(q[0].data));
    chk({tag, ".rd_perr"},   64'(rd_perr),   (n == 0) ? 64'd0 : 64'(q[0].perr));
  endtask

  // One received word: rx_done (and optionally rx_error) held high for 7 cycles.
  // Optionally asserts rd_en in the same cycle the push lands.
  task automatic send(input logic [DW-1:0] d, input bit e, input bit pop);
    bit popped;
    bit was_full;
    @(posedge PCLK); #1;
    rx_data_in = d;
    rx_done    = 1'b1;
    rx_error   = e;
    repeat (3) @(posedge PCLK);
    #1;
    chk("pre_push.count", 64'(count), 64'(q.size()));
    was_full = (q.size() == DEPTH);
    popped   = pop && (q.size() > 0);
    if (popped) begin
      chk("push_pop.head", 64'(rd_data), 64'(q[0].data));
    end
    rd_en = pop;
    @(posedge PCLK); #1;
    rd_en = 1'b0;
    if (popped) q.delete(0);
    if (was_full && !popped) begin
      m_ovr  = 1'b1;
      m_pend = 1'b0;
    end else begin
      q.push_back('{perr: m_pend | e, data: d});
      m_pend = 1'b0;
    end
    check_state("push");
    repeat (3) @(posedge PCLK);
    #1;
    rx_done  = 1'b0;
    rx_error = 1'b0;
    repeat (4) @(posedge PCLK);
    #1;
  endtask

  task automatic send_err();
    @(posedge PCLK); #1;
    rx_error = 1'b1;
    repeat (6) @(posedge PCLK);
    #1;
    rx_error = 1'b0;
    m_pend   = 1'b1;
    repeat (4) @(posedge PCLK);
    #1;
  endtask

  task automatic pop_one();
    @(posedge PCLK); #1;
    if (q.size() > 0) begin
      chk("pop.head_data", 64'(rd_data), 64'(q[0].data));
      chk("pop.head_perr", 64'(rd_perr), 64'(q[0].perr));
    end
    rd_en = 1'b1;
    @(posedge PCLK); #1;
    rd_en = 1'b0;
    if (q.size() > 0) q.delete(0);
    check_state("pop");
  endtask

  task automatic do_flush();
    @(posedge PCLK); #1;
    flush = 1'b1;
    @(posedge PCLK); #1;
    flush = 1'b0;
    q.delete();
    m_pend = 1'b0;
    check_state("flush");
  endtask

  task automatic do_ovr_clr();
    @(posedge PCLK); #1;
    ovr_clr = 1'b1;
    @(posedge PCLK); #1;
    ovr_clr = 1'b0;
    m_ovr = 1'b0;
    check_state("ovr_clr");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=no_finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] w0;
    logic [DW-1:0] d;

    // Reset
    repeat (3) @(posedge PCLK);
    #1;
    check_state("reset_hold");
    PRESET = 1'b0;
    @(posedge PCLK); #1;
    check_state("reset");

    // 1: single word, no error
    send(32'hA5A5_1234, 1'b0, 1'b0);
    chk("t1.rd_data", 64'(rd_data), 64'h0000_0000_A5A5_1234);
    chk("t1.count",   64'(count),   64'd1);
    pop_one();

    // 2: standalone error pulse attaches to the next word only
    send_err();
    send(32'h0000_0055, 1'b0, 1'b0);
    send(32'h0000_0066, 1'b0, 1'b0);
    chk("t2.perr_set", 64'(rd_perr), 64'd1);
    pop_one();
    chk("t2.perr_clr", 64'(rd_perr), 64'd0);
    chk("t2.data",     64'(rd_data), 64'h66);
    pop_one();

    // 3: DEPTH+1 words with no pops -> full and overrun, head unchanged
    w0 = $urandom;
    send(w0, 1'b0, 1'b0);
    for (int i = 1; i < DEPTH + 1; i++) begin
      send($urandom, ($urandom_range(0, 3) == 0), 1'b0);
    end
    chk("t3.full",    64'(full),    64'd1);
    chk("t3.count",   64'(count),   64'(DEPTH));
    chk("t3.overrun", 64'(overrun), 64'd1);
    chk("t3.head",    64'(rd_data), 64'(w0));
    do_ovr_clr();
    chk("t3.ovr_clr", 64'(overrun), 64'd0);

    // 4: push and pop together while full
    d = $urandom;
    send(d, 1'b1, 1'b1);
    chk("t4.count",   64'(count),   64'(DEPTH));
    chk("t4.overrun", 64'(overrun), 64'd0);
    for (int i = 0; i < DEPTH - 1; i++) pop_one();
    chk("t4.tail", 64'(rd_data), 64'(d));
    chk("t4.tail_perr", 64'(rd_perr), 64'd1);
    pop_one();

    // 5: 40 words with interleaved pops across pointer wrap, then pop on empty
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) == 0) send_err();
      send($urandom, ($urandom_range(0, 7) == 0), (q.size() > 0) && ($urandom_range(0, 1) == 1));
      if ($urandom_range(0, 2) == 0) pop_one();
    end
    while (q.size() > 0) pop_one();
    pop_one();
    chk("t5.empty", 64'(empty), 64'd1);
    if (m_ovr) do_ovr_clr();

    // 6: threshold / level_irq / flush / timeout
    threshold = CW'(4);
    for (int i = 0; i < 4; i++) begin
      send($urandom, 1'b0, 1'b0);
      if (i == 2) chk("t6.irq_below", 64'(level_irq), 64'd0);
    end
    chk("t6.irq_at", 64'(level_irq), 64'd1);
    threshold = '0;
    #1;
    check_state("t6.thr0");
    threshold = CW'(4);
    do_flush();
    chk("t6.flush_count", 64'(count),     64'd0);
    chk("t6.flush_irq",   64'(level_irq), 64'd0);

    send($urandom, 1'b0, 1'b0);
    repeat (TMO + 20) @(posedge PCLK);
    #1;
`ifdef UART_RX_TIMEOUT_EN
    chk("t6.timeout_set", 64'(rx_timeout), 64'd1);
`else
    chk("t6.timeout_off", 64'(rx_timeout), 64'd0);
`endif
    pop_one();
    chk("t6.timeout_clr", 64'(rx_timeout), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
